pwm_capture: RTL and testbench

Bus-readable PWM input capture block, the measuring counterpart of the PWM generator register block. It samples an external PWM signal, measures period and high time in prescaled clock ticks, and exposes the results through the same byte-wide addressed register bus the generator uses. Firmware uses it for closed-loop duty verification and for reading external PWM sources such as servo feedback and fan tachometers.

---
 rtl/pwm_capture.sv | 127 ++++++++++++
 tb/tb_pwm_capture.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: bus-readable PWM period/high-time capture with byte-wide register window.
// Optional 3-sample input glitch filter enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int StartAddress = 0,
  parameter int AddressWidth = 8,
  parameter int BitWidth = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic PWMIn,
  input  logic _Write,
  input  logic _Read,
  input  logic [AddressWidth-1:0] AddressBus,
  input  logic [BitWidth-1:0] DataIn,
  output logic [BitWidth-1:0] DataOut,
  output logic Captured
);
  typedef enum logic [1:0] {Idle, Arm, High, Low} stateT;
  stateT state, stateNext;
  logic sync0, sync1, prevLevel, levelNext, rise, fall;
  logic [15:0] preCnt, prescaler, periodCnt, highCnt, periodNext, highNext;
  logic [15:0] periodReg, highReg, highLatch;
  logic [23:0] shadow;
  logic enable, valid, overflow, tick, publish, latchHigh, counting, ovfSet;
  logic [AddressWidth-1:0] offset;
  logic hit, wrHit, rdHit, ctrlWr, clrWr, statusRd;
  logic [7:0] rdData;
  always_ff @(posedge CLK)
    if (RST) {sync0, sync1, prevLevel} <= '0;
    else {sync0, sync1, prevLevel} <= {PWMIn, sync0, levelNext};
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] hist;
  always_ff @(posedge CLK)
    if (RST) hist <= '0;
    else hist <= {hist[0], sync1};
  // prevLevel doubles as the filtered level and the edge-detect register
  assign levelNext = (hist == {2{sync1}}) ? sync1 : prevLevel;
`else
  assign levelNext = sync1;
`endif
  assign rise = levelNext & ~prevLevel;
  assign fall = ~levelNext & prevLevel;
  assign tick = preCnt >= prescaler;
  // the wrap on the edge cycle itself is included so results equal floor(N/(P+1))
  assign periodNext = periodCnt + 16'(tick && periodCnt != 16'hFFFF);
  assign highNext = highCnt + 16'(tick && highCnt != 16'hFFFF);
  always_ff @(posedge CLK)
    if (RST || rise) begin
      preCnt <= '0;
      periodCnt <= '0;
      highCnt <= '0;
    end else begin
      preCnt <= tick ? '0 : preCnt + 16'd1;
      periodCnt <= periodNext;
      highCnt <= highNext;
    end
  always_ff @(posedge CLK) state <= RST ? Idle : stateNext;
  always_comb
    stateNext = clrWr ? (DataIn[0] ? Arm : Idle) :
                !enable ? Idle :
                (state == Idle) ? Arm :
                (state == Arm && rise) ? High :
                (state == High && fall) ? Low :
                (state == Low && rise) ? High : state;
  always_comb begin
    counting = state == High || state == Low;
    publish = state == Low && rise && !clrWr;
    latchHigh = state == High && fall && !clrWr;
    ovfSet = counting && tick && (periodCnt == 16'hFFFF || (state == High && highCnt == 16'hFFFF));
  end
  assign offset = AddressBus - AddressWidth'(StartAddress);
  assign hit = offset < AddressWidth'(8);
  assign wrHit = !_Write && hit;
  assign rdHit = !_Read && hit;
  assign ctrlWr = wrHit && offset == AddressWidth'(5);
  assign clrWr = ctrlWr && DataIn[1];
  assign statusRd = rdHit && offset == AddressWidth'(4);
  always_ff @(posedge CLK)
    if (RST) begin
      enable <= 1'b0;
      prescaler <= '0;
    end else begin
      if (ctrlWr) enable <= DataIn[0];
      if (wrHit && offset == AddressWidth'(6)) prescaler[15:8] <= DataIn;
      if (wrHit && offset == AddressWidth'(7)) prescaler[7:0] <= DataIn;
    end
  // a flag set in the same cycle as a Status read wins over the read-clear
  always_ff @(posedge CLK)
    if (RST || clrWr) begin
      periodReg <= '0;
      highReg <= '0;
      highLatch <= '0;
      valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (latchHigh) highLatch <= highNext;
      if (publish) begin
        periodReg <= periodNext;
        highReg <= highLatch;
      end
      valid <= publish || (valid && !statusRd);
      overflow <= ovfSet || (overflow && !statusRd);
    end
  always_ff @(posedge CLK) Captured <= RST ? 1'b0 : publish;
  always_comb begin
    rdData = 8'h00;
    if (hit)
      case (offset[2:0])
        3'd0: rdData = periodReg[15:8];
        3'd1: rdData = shadow[23:16];
        3'd2: rdData = shadow[15:8];
        3'd3: rdData = shadow[7:0];
        3'd4: rdData = {4'b0, enable, prevLevel, overflow, valid};
        3'd5: rdData = {7'b0, enable};
        3'd6: rdData = prescaler[15:8];
        default: rdData = prescaler[7:0];
      endcase
  end
  always_ff @(posedge CLK)
    if (RST) begin
      DataOut <= '0;
      shadow <= '0;
    end else if (!_Read) begin
      DataOut <= rdData;
      if (rdHit && offset == '0) shadow <= {periodReg[7:0], highReg};
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture; reads push expected bytes, a monitor pops and compares.
module tb_pwm_capture;
  logic clk = 0, rst = 1, pwmIn = 0, nWrite = 1, nRead = 1;
  logic [7:0] addr = 0, dataIn = 0, dataOut;
  logic captured;
  int checks = 0, failures = 0;
  logic [7:0] expQ[$];
  string nameQ[$];
  logic [7:0] expV;
  string nameV;
  logic rdSeen = 0;
  int cyc = 0, capCount = 0, lastCap = 0, lastGap = 0, capBase = 0;
  logic pwmRun = 0, pwmLevel = 0;
  int hiT = 3, loT = 5, phase = 0;

  pwm_capture dut (
    .CLK(clk), .RST(rst), .PWMIn(pwmIn), ._Write(nWrite), ._Read(nRead),
    .AddressBus(addr), .DataIn(dataIn), .DataOut(dataOut), .Captured(captured)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rdSeen <= !nRead && !rst;
  end

  always @(negedge clk) begin
    if (captured) begin
      lastGap = cyc - lastCap;
      lastCap = cyc;
      capCount++;
    end
    if (rdSeen) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL unexpected read: DataOut=%02h with empty scoreboard", dataOut);
      end else begin
        expV = expQ.pop_front();
        nameV = nameQ.pop_front();
        if (dataOut !== expV) begin
          failures++;
          $display("FAIL %s: DataOut=%02h expected %02h", nameV, dataOut, expV);
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (!pwmRun) begin
      phase = 0;
      pwmIn = pwmLevel;
    end else begin
      pwmIn = phase < hiT;
      phase = (phase + 1 == hiT + loT) ? 0 : phase + 1;
    end
  end

  task automatic wrReg(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    nWrite = 0; addr = a; dataIn = d;
    @(negedge clk);
    nWrite = 1;
  endtask

  task automatic rdExp(input logic [7:0] a, input logic [7:0] e, input string n);
    @(negedge clk);
    nRead = 0; addr = a;
    expQ.push_back(e);
    nameQ.push_back(n);
    @(negedge clk);
    nRead = 1;
  endtask

  task automatic check(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic waitCap(input string n);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!captured && k < 300);
    checks++;
    if (!captured) begin
      failures++;
      $display("FAIL %s: no Captured pulse within 300 cycles", n);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset DataOut", int'(dataOut), 0);
    check("reset Captured", int'(captured), 0);
    rst = 0;
    // prescaler 0, 3 high / 5 low
    wrReg(8'd5, 8'h01);
    hiT = 3; loT = 5; pwmRun = 1;
    repeat (3) waitCap("t1 capture");
    repeat (2) @(negedge clk);
    pwmRun = 0; pwmLevel = 0;
    check("t1 capture gap", lastGap, 8);
    rdExp(8'd0, 8'h00, "t1 periodU");
    rdExp(8'd1, 8'h08, "t1 periodL");
    rdExp(8'd2, 8'h00, "t1 highU");
    rdExp(8'd3, 8'h03, "t1 highL");
    rdExp(8'd4, 8'h09, "t1 status");
    rdExp(8'd4, 8'h08, "t1 status reread");
    // prescaler 3, 40 high / 60 low
    wrReg(8'd7, 8'h03);
    hiT = 40; loT = 60; pwmRun = 1;
    repeat (3) waitCap("t2 capture");
    repeat (50) @(negedge clk);
    pwmRun = 0; pwmLevel = 0;
    check("t2 capture gap", lastGap, 100);
    rdExp(8'd0, 8'h00, "t2 periodU");
    rdExp(8'd1, 8'h19, "t2 periodL");
    rdExp(8'd2, 8'h00, "t2 highU");
    rdExp(8'd3, 8'h0A, "t2 highL");
    // snapshot coherence across a publish
    rdExp(8'd0, 8'h00, "t3 snap periodU");
    wrReg(8'd7, 8'h00);
    repeat (100) @(negedge clk);
    pwmLevel = 1;
    waitCap("t3 capture");
    rdExp(8'd1, 8'h19, "t3 snap periodL");
    rdExp(8'd2, 8'h00, "t3 snap highU");
    rdExp(8'd3, 8'h0A, "t3 snap highL");
    // clear mid-HIGH with enable kept
    wrReg(8'd5, 8'h03);
    rdExp(8'd0, 8'h00, "t4 cleared periodU");
    rdExp(8'd1, 8'h00, "t4 cleared periodL");
    rdExp(8'd2, 8'h00, "t4 cleared highU");
    rdExp(8'd3, 8'h00, "t4 cleared highL");
    rdExp(8'd4, 8'h0C, "t4 status after clear");
    rdExp(8'd5, 8'h01, "t4 control readback");
    capBase = capCount;
    pwmLevel = 0; repeat (10) @(negedge clk);
    pwmLevel = 1; repeat (6) @(negedge clk);
    pwmLevel = 0; repeat (4) @(negedge clk);
    check("t4 no publish from first rise", capCount - capBase, 0);
    pwmLevel = 1;
    waitCap("t4 capture");
    rdExp(8'd0, 8'h00, "t4 periodU");
    rdExp(8'd1, 8'h0A, "t4 periodL");
    rdExp(8'd2, 8'h00, "t4 highU");
    rdExp(8'd3, 8'h06, "t4 highL");
    // saturation
    pwmLevel = 0; repeat (10) @(negedge clk);
    pwmLevel = 1; repeat (70000) @(negedge clk);
    pwmLevel = 0; repeat (10) @(negedge clk);
    pwmLevel = 1;
    waitCap("t6 capture");
    rdExp(8'd0, 8'hFF, "t6 periodU");
    rdExp(8'd1, 8'hFF, "t6 periodL");
    rdExp(8'd2, 8'hFF, "t6 highU");
    rdExp(8'd3, 8'hFF, "t6 highL");
    rdExp(8'd4, 8'h0F, "t6 status overflow");
    rdExp(8'd4, 8'h0C, "t6 status reread");
    // prescaler access, unmapped addresses, reset mid-LOW
    pwmLevel = 0; repeat (10) @(negedge clk);
    wrReg(8'd6, 8'h12);
    wrReg(8'd7, 8'h34);
    rdExp(8'd6, 8'h12, "t5 prescalerU");
    rdExp(8'd7, 8'h34, "t5 prescalerL");
    rdExp(8'd5, 8'h01, "t5 control");
    wrReg(8'h0E, 8'hFF);
    rdExp(8'd6, 8'h12, "t5 unmapped write ignored");
    rdExp(8'h20, 8'h00, "t5 unmapped read");
    rdExp(8'd7, 8'h34, "t5 prescalerL again");
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    check("t5 reset DataOut", int'(dataOut), 0);
    check("t5 reset Captured", int'(captured), 0);
    rst = 0;
    for (int a = 0; a < 8; a++) rdExp(8'(a), 8'h00, "t5 post-reset register");
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    wrReg(8'd5, 8'h01);
    pwmLevel = 0; repeat (10) @(negedge clk);
    pwmLevel = 1; repeat (10) @(negedge clk);
    pwmLevel = 0; repeat (2) @(negedge clk);
    pwmLevel = 1; repeat (10) @(negedge clk);
    pwmLevel = 0; repeat (8) @(negedge clk);
    pwmLevel = 1;
    waitCap("t7 capture");
    rdExp(8'd0, 8'h00, "t7 periodU");
    rdExp(8'd1, 8'h1E, "t7 periodL");
    rdExp(8'd2, 8'h00, "t7 highU");
    rdExp(8'd3, 8'h16, "t7 highL glitch rejected");
`endif
    repeat (3) @(negedge clk);
    check("scoreboard drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
